// File: rtl/merge_block_feeder.sv
// merge_block_feeder: packs a serial stream of signed samples into 32-sample
// blocks held in two ping-pong banks, then sends each block to the sorter as
// 8 back-to-back beats of 4 lanes. Block starts are spaced by BLK_PERIOD.
module merge_block_feeder #(
    parameter int DATA_W     = 8,
    parameter int BLK_PERIOD = 32,
    parameter int PAD_VAL    = -128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic                     BlkIn,
    output logic signed [DATA_W-1:0] In1,
    output logic signed [DATA_W-1:0] In2,
    output logic signed [DATA_W-1:0] In3,
    output logic signed [DATA_W-1:0] In4,
    output logic                     busy,
    output logic [15:0]              blk_count
);

    localparam logic signed [DATA_W-1:0] PAD = PAD_VAL[DATA_W-1:0];
    localparam logic [7:0] GAP_MAX = BLK_PERIOD[7:0];
    // Starting on the coming edge places BlkIn gap_cnt+1 cycles after the last one.
    localparam logic [7:0] GAP_MIN = GAP_MAX - 8'd1;

    typedef enum logic [1:0] {IDLE, WAIT_GAP, SEND} state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] bank [2][32];
    logic [1:0] full, full_nxt;
    logic       fill, fill_nxt;
    logic [4:0] fill_idx;
    logic       tx_bank;
    logic [2:0] beat;
    logic [7:0] gap_cnt;

    logic       accept, close_blk, start, done, gap_ok;
    logic       rd_bank;
    logic [2:0] rd_beat;

    // Fill side: accept, block close, bank occupancy and fill-bank switching.
    always_comb begin
        accept    = s_valid && s_ready;
        close_blk = accept && (s_last || fill_idx == 5'd31);
        full_nxt  = full;
        if (done) begin
            full_nxt[tx_bank] = 1'b0;
        end
        if (close_blk) begin
            full_nxt[fill] = 1'b1;
        end
        fill_nxt = fill;
        if (full_nxt[fill] && !full_nxt[!fill]) begin
            fill_nxt = !fill;
        end
    end

    // TX FSM next state; the pending bank is always the one not being filled.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        gap_ok    = (gap_cnt >= GAP_MIN);
        rd_bank   = tx_bank;
        rd_beat   = beat + 3'd1;
        unique case (state)
            IDLE: begin
                if (full[!fill]) begin
                    if (gap_ok) begin
                        state_nxt = SEND;
                        start     = 1'b1;
                    end else begin
                        state_nxt = WAIT_GAP;
                    end
                end
            end
            WAIT_GAP: begin
                if (gap_ok) begin
                    state_nxt = SEND;
                    start     = 1'b1;
                end
            end
            SEND: begin
                if (beat == 3'd7) begin
                    done      = 1'b1;
                    state_nxt = full[fill] ? WAIT_GAP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            rd_bank = !fill;
            rd_beat = 3'd0;
        end
    end

    // Control state, gap counter, block counter and registered beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            full      <= 2'b00;
            fill      <= 1'b0;
            fill_idx  <= 5'd0;
            tx_bank   <= 1'b0;
            beat      <= 3'd0;
            gap_cnt   <= GAP_MAX;
            s_ready   <= 1'b0;
            blk_count <= 16'd0;
            BlkIn     <= 1'b0;
            busy      <= 1'b0;
            In1       <= '0;
            In2       <= '0;
            In3       <= '0;
            In4       <= '0;
        end else begin
            state   <= state_nxt;
            full    <= full_nxt;
            fill    <= fill_nxt;
            s_ready <= !full_nxt[fill_nxt];
            if (accept) begin
                fill_idx <= close_blk ? 5'd0 : fill_idx + 5'd1;
            end
            if (start) begin
                tx_bank <= !fill;
                beat    <= 3'd0;
            end else if (state == SEND) begin
                beat <= beat + 3'd1;
            end
            if (start) begin
                gap_cnt <= 8'd0;
            end else if (gap_cnt < GAP_MAX) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
            if (state == SEND && beat == 3'd6) begin
                blk_count <= blk_count + 16'd1;
            end
            BlkIn <= start;
            busy  <= start || (state == SEND && !done);
            if (start || (state == SEND && !done)) begin
                In1 <= bank[rd_bank][{rd_beat, 2'd0}];
                In2 <= bank[rd_bank][{rd_beat, 2'd1}];
                In3 <= bank[rd_bank][{rd_beat, 2'd2}];
                In4 <= bank[rd_bank][{rd_beat, 2'd3}];
            end else begin
                In1 <= '0;
                In2 <= '0;
                In3 <= '0;
                In4 <= '0;
            end
        end
    end

    // Bank storage: write the accepted sample, and pad the tail on s_last.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            for (int k = 0; k < 32; k++) begin
                if (k[4:0] == fill_idx) begin
                    bank[fill][k[4:0]] <= s_data;
                end else if (s_last && k[4:0] > fill_idx) begin
                    bank[fill][k[4:0]] <= PAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_merge_block_feeder.sv
// Bench for merge_block_feeder: two instances (BLK_PERIOD 32 and 64) driven by
// directed streams, checked every cycle against a queue-level block model plus
// hand-computed literal expectations.
module tb_merge_block_feeder;

    localparam int P0 = 32;
    localparam int P1 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      s_valid;
    logic [1:0]      s_last;
    logic [1:0][7:0] s_data;
    wire  [1:0]      s_ready;
    wire  [1:0]      blkin;
    wire  [1:0]      busy;
    wire  [1:0][7:0] l1, l2, l3, l4;
    wire  [1:0][15:0] cnt;

    merge_block_feeder #(.DATA_W(8), .BLK_PERIOD(P0), .PAD_VAL(-128)) u0 (
        .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_data(s_data[0]),
        .s_last(s_last[0]), .s_ready(s_ready[0]), .BlkIn(blkin[0]),
        .In1(l1[0]), .In2(l2[0]), .In3(l3[0]), .In4(l4[0]),
        .busy(busy[0]), .blk_count(cnt[0])
    );

    merge_block_feeder #(.DATA_W(8), .BLK_PERIOD(P1), .PAD_VAL(-128)) u1 (
        .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_data(s_data[1]),
        .s_last(s_last[1]), .s_ready(s_ready[1]), .BlkIn(blkin[1]),
        .In1(l1[1]), .In2(l2[1]), .In3(l3[1]), .In4(l4[1]),
        .busy(busy[1]), .blk_count(cnt[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stalls = 0;
    bit model_on = 1'b0;
    int blk_hist[$];

    // Model state: completed blocks waiting, the block on the wire, the block filling.
    int pend [2][2][32];
    int pcnt [2];
    int fbuf [2][32];
    int fcnt [2];
    int txd  [2][32];
    bit sending [2];
    int beat_m [2];
    int since [2];
    bit e_rdy [2];
    int e_cnt [2];
    int m_per;
    bit m_acc;

    // Model: one update per rising edge, from the block-level rules.
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            m_per = (d == 0) ? P0 : P1;
            if (rst) begin
                pcnt[d] = 0; fcnt[d] = 0; sending[d] = 1'b0; beat_m[d] = 0;
                since[d] = m_per; e_rdy[d] = 1'b0; e_cnt[d] = 0;
            end else begin
                m_acc = s_valid[d] && e_rdy[d];
                if (since[d] < 1000) since[d]++;
                if (sending[d]) begin
                    if (beat_m[d] == 7) begin
                        sending[d] = 1'b0;
                    end else begin
                        beat_m[d]++;
                        if (beat_m[d] == 7) e_cnt[d] = (e_cnt[d] + 1) % 65536;
                    end
                end else if (pcnt[d] > 0 && since[d] >= m_per) begin
                    for (int k = 0; k < 32; k++) begin
                        txd[d][k] = pend[d][0][k];
                        pend[d][0][k] = pend[d][1][k];
                    end
                    pcnt[d]--;
                    sending[d] = 1'b1;
                    beat_m[d] = 0;
                    since[d] = 0;
                end
                if (m_acc) begin
                    fbuf[d][fcnt[d]] = $signed(s_data[d]);
                    fcnt[d]++;
                    if (fcnt[d] == 32 || s_last[d]) begin
                        for (int k = 0; k < 32; k++)
                            pend[d][pcnt[d]][k] = (k < fcnt[d]) ? fbuf[d][k] : -128;
                        pcnt[d]++;
                        fcnt[d] = 0;
                    end
                end
                e_rdy[d] = (pcnt[d] + (sending[d] ? 1 : 0)) < 2;
            end
        end
        model_on = 1'b1;
    end

    function automatic int lane(input int d, input int l);
        case (l)
            0: lane = $signed(l1[d]);
            1: lane = $signed(l2[d]);
            2: lane = $signed(l3[d]);
            default: lane = $signed(l4[d]);
        endcase
    endfunction

    task automatic cmp_one(input int d);
        int el[4];
        int eb, ebu;
        bit bad;
        ebu = sending[d] ? 1 : 0;
        eb  = (sending[d] && beat_m[d] == 0) ? 1 : 0;
        for (int l = 0; l < 4; l++) el[l] = sending[d] ? txd[d][beat_m[d] * 4 + l] : 0;
        bad = (s_ready[d] !== e_rdy[d]) || (blkin[d] !== 1'(eb)) || (busy[d] !== 1'(ebu))
              || (cnt[d] !== 16'(e_cnt[d]));
        for (int l = 0; l < 4; l++) if (lane(d, l) != el[l]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL model_u%0d cyc=%0d got rdy=%b blk=%b busy=%b lanes=%0d,%0d,%0d,%0d cnt=%0d required rdy=%0d blk=%0d busy=%0d lanes=%0d,%0d,%0d,%0d cnt=%0d",
                     d, cyc, s_ready[d], blkin[d], busy[d], lane(d, 0), lane(d, 1), lane(d, 2), lane(d, 3), cnt[d],
                     e_rdy[d], eb, ebu, el[0], el[1], el[2], el[3], e_cnt[d]);
        end
    endtask

    // Compare: both instances against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            for (int d = 0; d < 2; d++) cmp_one(d);
            if (blkin[0] === 1'b1) blk_hist.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int d, input int v, input bit last);
        int n;
        n = 0;
        s_valid[d] = 1'b1;
        s_data[d]  = 8'(v);
        s_last[d]  = last;
        while (!s_ready[d] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL send_u%0d: s_ready low for %0d cycles", d, n);
        end
        stalls += n;
        @(negedge clk);
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    task automatic wait_blk(input int d, output int n);
        n = 0;
        while (blkin[d] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (blkin[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_blk_u%0d: BlkIn not seen in %0d cycles", d, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        s_valid = '0;
        s_last = '0;
        s_data = '0;
        idle(3);
        chk("reset_ready", int'(s_ready[0]), 0);
        chk("reset_blkin", int'(blkin[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_cnt", int'(cnt[0]), 0);
        chk("reset_in1", lane(0, 0), 0);
        rst = 1'b0;
        idle(1);
        chk("ready_after_reset", int'(s_ready[0]), 1);

        // Single block 0..31
        for (int k = 0; k < 32; k++) send(0, k, 1'b0);
        wait_blk(0, n);
        chk("t1_latency", n, 1);
        for (int l = 0; l < 4; l++) chk("t1_beat0_lane", lane(0, l), l);
        idle(7);
        for (int l = 0; l < 4; l++) chk("t1_beat7_lane", lane(0, l), 28 + l);
        chk("t1_cnt", int'(cnt[0]), 1);
        idle(40);

        // Early close after 5 samples
        for (int k = 1; k <= 5; k++) send(0, -k, k == 5);
        wait_blk(0, n);
        for (int l = 0; l < 4; l++) chk("t3_beat0_lane", lane(0, l), -(l + 1));
        idle(1);
        chk("t3_beat1_in1", lane(0, 0), -5);
        for (int l = 1; l < 4; l++) chk("t3_beat1_pad", lane(0, l), -128);
        idle(40);

        // Signed extremes, alternating 127 / -128
        for (int k = 0; k < 32; k++) send(0, (k % 2 == 0) ? 127 : -128, 1'b0);
        wait_blk(0, n);
        for (int b = 0; b < 8; b++) begin
            chk("t6_in1", lane(0, 0), 127);
            chk("t6_in2", lane(0, 1), -128);
            idle(1);
        end
        idle(40);

        // Continuous stream of 96 samples
        blk_hist.delete();
        stalls = 0;
        for (int k = 0; k < 96; k++) send(0, (k * 5) % 256 - 128, 1'b0);
        chk("t2_no_stall", stalls, 0);
        idle(45);
        chk("t2_pulses", blk_hist.size(), 3);
        if (blk_hist.size() == 3) begin
            chk("t2_gap01", blk_hist[1] - blk_hist[0], 32);
            chk("t2_gap12", blk_hist[2] - blk_hist[1], 32);
        end
        chk("t2_cnt", int'(cnt[0]), 6);

        // Backpressure on the BLK_PERIOD=64 instance
        stalls = 0;
        for (int k = 0; k < 128; k++) send(1, (k * 37 + 11) % 256 - 128, 1'b0);
        chk("t4_stalled", (stalls > 0) ? 1 : 0, 1);
        n = 0;
        while (cnt[1] != 16'd4 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("t4_cnt", int'(cnt[1]), 4);
        idle(20);

        // Reset during beat 3, then a fresh block
        for (int k = 0; k < 32; k++) send(0, k - 16, 1'b0);
        wait_blk(0, n);
        idle(3);
        rst = 1'b1;
        idle(1);
        chk("t5_blkin", int'(blkin[0]), 0);
        chk("t5_busy", int'(busy[0]), 0);
        chk("t5_in1", lane(0, 0), 0);
        chk("t5_cnt", int'(cnt[0]), 0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) send(0, 50 - k, 1'b0);
        wait_blk(0, n);
        chk("t5_latency", n, 1);
        for (int l = 0; l < 4; l++) chk("t5_beat0_lane", lane(0, l), 50 - l);
        idle(7);
        chk("t5_cnt_after", int'(cnt[0]), 1);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
